// File: rtl/frac_reduce.sv
// Divides num and den by hcf with a shared restoring divider, one quotient bit per clock.
// Result appears 2*WIDTH edges after accept (next cycle if hcf==0); results held in DONE until out_ready.
module frac_reduce #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] num,
   input  logic [WIDTH-1:0] den,
   input  logic [WIDTH-1:0] hcf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] red_num,
   output logic [WIDTH-1:0] red_den,
   output logic             err_zero,
   output logic             inexact
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DIV_NUM = 2'd1;
   localparam logic [1:0] S_DIV_DEN = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hcf;
   logic [WIDTH-1:0] r_den;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_qnum;
   logic             r_nz_num;
   logic [WIDTH-1:0] r_red_num;
   logic [WIDTH-1:0] r_red_den;
   logic             r_err_zero;
   logic             r_inexact;

   logic [WIDTH:0]   w_rem_sh;
   logic             w_ge;
   logic [WIDTH:0]   w_rem_nx;
   logic [WIDTH-1:0] w_quo_nx;
   logic             w_last;
   logic             w_accept;

   // One extra remainder bit keeps the shifted value exact when hcf exceeds 2^(WIDTH-1).
   assign w_rem_sh = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_hcf});
   assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_hcf}) : w_rem_sh;
   assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
   assign w_last   = (r_cnt == LAST_STEP);
   assign w_accept = in_valid && in_ready;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign red_num   = r_red_num;
   assign red_den   = r_red_den;
   assign err_zero  = r_err_zero;
   assign inexact   = r_inexact;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_hcf      <= '0;
         r_den      <= '0;
         r_dvd      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_qnum     <= '0;
         r_nz_num   <= 1'b0;
         r_red_num  <= '0;
         r_red_den  <= '0;
         r_err_zero <= 1'b0;
         r_inexact  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_hcf <= hcf;
                  r_den <= den;
                  r_dvd <= num;
                  r_rem <= '0;
                  r_quo <= '0;
                  r_cnt <= '0;
                  if (hcf == '0) begin
                     r_red_num  <= num;
                     r_red_den  <= den;
                     r_err_zero <= 1'b1;
                     r_inexact  <= 1'b0;
                     r_state    <= S_DONE;
                  end else begin
                     r_state <= S_DIV_NUM;
                  end
               end
            end
            S_DIV_NUM: begin
               r_cnt <= r_cnt + 1'b1;
               r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               if (w_last) begin
                  r_qnum   <= w_quo_nx;
                  r_nz_num <= (w_rem_nx != '0);
                  r_dvd    <= r_den;
                  r_rem    <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_DIV_DEN;
               end
            end
            S_DIV_DEN: begin
               r_cnt <= r_cnt + 1'b1;
               r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               if (w_last) begin
                  r_red_num  <= r_qnum;
                  r_red_den  <= w_quo_nx;
                  r_inexact  <= r_nz_num || (w_rem_nx != '0);
                  r_err_zero <= 1'b0;
                  r_cnt      <= '0;
                  r_state    <= S_DONE;
               end
            end
            default: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frac_reduce.sv
// Directed bench for frac_reduce: latency, reduced values, flags, backpressure and mid-op reset.
module tb_frac_reduce;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] num, den, hcf;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] red_num, red_den;
   logic         err_zero, inexact;

   int n_checks = 0;
   int n_errors = 0;
   int lat;

   always #5 clk = ~clk;

   frac_reduce #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .num       (num),
      .den       (den),
      .hcf       (hcf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .red_num   (red_num),
      .red_den   (red_den),
      .err_zero  (err_zero),
      .inexact   (inexact)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Accepts one operand set, scrambles the inputs, then counts edges after accept until out_valid.
   task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] h,
                         output int l);
      @(negedge clk);
      num = n; den = d; hcf = h; in_valid = 1'b1;
      chk("in_ready_before_accept", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      num = W'($urandom); den = W'($urandom); hcf = W'($urandom);
      l = 0;
      while (!out_valid && l < 40) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   task automatic expect_xfer(input string tag);
      @(posedge clk);
      #1;
      chk({tag, "_out_valid_after"}, out_valid, 0);
      chk({tag, "_in_ready_after"}, in_ready, 1);
   endtask

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; num = '0; den = '0; hcf = '0; out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_red_num", red_num, 0);
      chk("rst_red_den", red_den, 0);
      chk("rst_err_zero", err_zero, 0);
      chk("rst_inexact", inexact, 0);
      @(negedge clk) rst_n = 1'b1;

      // 12/18 by 6
      run_op(8'd12, 8'd18, 8'd6, lat);
      chk("a_latency", lat, 16);
      chk("a_red_num", red_num, 2);
      chk("a_red_den", red_den, 3);
      chk("a_inexact", inexact, 0);
      chk("a_err_zero", err_zero, 0);
      expect_xfer("a");

      // 255/255 by 255
      run_op(8'd255, 8'd255, 8'd255, lat);
      chk("b_latency", lat, 16);
      chk("b_red_num", red_num, 1);
      chk("b_red_den", red_den, 1);
      chk("b_inexact", inexact, 0);
      expect_xfer("b");

      // 200/0 by 200
      run_op(8'd200, 8'd0, 8'd200, lat);
      chk("c_red_num", red_num, 1);
      chk("c_red_den", red_den, 0);
      chk("c_inexact", inexact, 0);
      expect_xfer("c");

      // 255/254 by 200: 1 r55, 1 r54
      run_op(8'd255, 8'd254, 8'd200, lat);
      chk("d_red_num", red_num, 1);
      chk("d_red_den", red_den, 1);
      chk("d_inexact", inexact, 1);
      expect_xfer("d");

      // 10/15 by 4: 2 r2, 3 r3
      run_op(8'd10, 8'd15, 8'd4, lat);
      chk("e_latency", lat, 16);
      chk("e_red_num", red_num, 2);
      chk("e_red_den", red_den, 3);
      chk("e_inexact", inexact, 1);
      chk("e_err_zero", err_zero, 0);
      expect_xfer("e");

      // hcf=0: pass-through, valid in the cycle right after accept
      run_op(8'd10, 8'd15, 8'd0, lat);
      chk("f_latency", lat, 0);
      chk("f_red_num", red_num, 10);
      chk("f_red_den", red_den, 15);
      chk("f_err_zero", err_zero, 1);
      chk("f_inexact", inexact, 0);
      expect_xfer("f");

      // 8/9 by 4: remainder only on den; err_zero must clear
      run_op(8'd8, 8'd9, 8'd4, lat);
      chk("g_red_num", red_num, 2);
      chk("g_red_den", red_den, 2);
      chk("g_inexact", inexact, 1);
      chk("g_err_zero", err_zero, 0);
      expect_xfer("g");

      // 7/4 by 2: remainder only on num
      run_op(8'd7, 8'd4, 8'd2, lat);
      chk("h_red_num", red_num, 3);
      chk("h_red_den", red_den, 2);
      chk("h_inexact", inexact, 1);
      expect_xfer("h");

      // 0/12 by 4
      run_op(8'd0, 8'd12, 8'd4, lat);
      chk("i_red_num", red_num, 0);
      chk("i_red_den", red_den, 3);
      chk("i_inexact", inexact, 0);
      expect_xfer("i");

      // Backpressure: 100/75 by 25 held for 5 cycles while in_valid pulses
      out_ready = 1'b0;
      run_op(8'd100, 8'd75, 8'd25, lat);
      chk("bp_latency", lat, 16);
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0] ? 1'b0 : 1'b1;
         num = 8'd1; den = 8'd1; hcf = 8'd0;
         @(posedge clk);
         #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_red_num", red_num, 4);
         chk("bp_red_den", red_den, 3);
         chk("bp_err_zero", err_zero, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      expect_xfer("bp");
      chk("bp_red_num_kept", red_num, 4);
      chk("bp_red_den_kept", red_den, 3);
      @(posedge clk);
      #1;
      chk("bp_no_ghost_op", out_valid, 0);

      // Reset during the 7th division cycle
      @(negedge clk);
      num = 8'd12; den = 8'd18; hcf = 8'd6; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      chk("rs_busy_in_ready", in_ready, 0);
      chk("rs_busy_out_valid", out_valid, 0);
      rst_n = 1'b0;
      #1;
      chk("rs_in_ready", in_ready, 1);
      chk("rs_out_valid", out_valid, 0);
      chk("rs_red_num", red_num, 0);
      chk("rs_red_den", red_den, 0);
      @(negedge clk) rst_n = 1'b1;

      run_op(8'd9, 8'd27, 8'd9, lat);
      chk("rs_new_latency", lat, 16);
      chk("rs_new_red_num", red_num, 1);
      chk("rs_new_red_den", red_den, 3);
      chk("rs_new_inexact", inexact, 0);
      expect_xfer("rs_new");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
